flash_word_writer: RTL and testbench
====================================

# flash_word_writer

Programs flash memory from a byte stream, in the opposite direction to the flash byte fetch path. It accepts bytes over a valid/ready handshake and packs four bytes into one 32-bit word. Each full word is issued as a single-beat Avalon-MM write on the flash_mem master port. It runs on the 50 MHz system clock and is started by the loader or control FSM with a base word address and a word count. Forward or reverse ordering mirrors the fetch path, so reverse playback of written data round-trips.

## Interface
- FLASH_ADDR_W, 23, word-address width of flash_mem_address
- clk  in  1  system clock (CLK_50M domain)
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle pulse; sampled only in IDLE
- reverse  in  1  sampled with start; 0 = ascending words, lane 0 first; 1 = descending words, lane 3 first
- base_addr  in  FLASH_ADDR_W  first word address, sampled with start
- word_count  in  FLASH_ADDR_W  number of words to write, sampled with start
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte_in this cycle
- flash_mem_write  out  1  Avalon write request
- flash_mem_address  out  FLASH_ADDR_W  word address
- flash_mem_writedata  out  32  packed word
- flash_mem_byteenable  out  4  always 4'b1111
- flash_mem_burstcount  out  6  always 6'd1
- flash_mem_waitrequest  in  1  slave stall
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last word is accepted

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr, word_count and reverse; lane index is cleared.
  - word_count=0 goes to DONE; otherwise goes to FILL.
- FILL:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Forward: the k-th accepted byte (k=0..3) goes to writedata[8k+7:8k].
  - Reverse: the k-th accepted byte goes to writedata[31-8k:24-8k].
  - Accepting the 4th byte moves to WRITE.
- WRITE:
  - byte_ready=0 and flash_mem_write=1.
  - Address and writedata stay stable while waitrequest=1.
  - The write is accepted on a cycle with write && !waitrequest.
  - On acceptance, remaining word count decrements; address increments (forward) or decrements (reverse), modulo 2^FLASH_ADDR_W.
  - If this was the last word, go to DONE; otherwise go to FILL with lane index cleared.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- byte_valid outside FILL is not accepted; the source holds the byte.
- reset=0 on any edge aborts the transfer: state goes to IDLE and partial words are discarded, with no write issued.

## Timing
- Reset values:
  - byte_ready=0, flash_mem_write=0, flash_mem_address=0, flash_mem_writedata=0, busy=0, done=0.
  - flash_mem_byteenable=4'hF and flash_mem_burstcount=1 are constant.
- start at edge T: busy=1 from T+1 and FILL from T+1. With word_count=0, DONE at T+1 and done=1 during T+1.
- byte_ready and flash_mem_write are Moore outputs decoded from state only, with no combinational path from inputs.
- 4th byte accepted at edge N: flash_mem_write=1 from N+1.
- Write accepted at edge M: write=0 from M+1. FILL, or DONE, begins at M+1.
- Best-case throughput is 5 cycles per word: 4 fill cycles plus 1 write cycle.
- Address wrap: forward from 23'h7FFFFF goes to 0; reverse from 0 goes to 23'h7FFFFF. There is no error flag.

## Structure
- flash_pkg holds:
  - FLASH_ADDR_W
  - BURST_SINGLE = 6'd1
  - BYTE_EN_ALL = 4'hF
  - the writer state enum (IDLE, FILL, WRITE, DONE)
- One sub-module, byte_packer. It holds the 2-bit lane counter and the 32-bit shift/insert register, with inputs clear, load, reverse and byte_in, and outputs word and full. The top level owns the FSM, the address and the remaining-word counter.

## Test plan
- Forward, single word: base=0x000010, count=1, bytes 11,22,33,44 with no stall. Expect one write at addr 0x000010, data 0x44332211; done 1 cycle after acceptance.
- Reverse, two words: base=0x000020, bytes AA,BB,CC,DD,01,02,03,04. Expect writes 0xAABBCCDD@0x20 then 0x01020304@0x1F.
- Waitrequest held 3 cycles during WRITE: address and data stay stable, byte_ready stays 0, and exactly one write is accepted.
- Source gaps: byte_valid toggles 1,0,0,1,... Packing order is unaffected and no byte is dropped or duplicated.
- Boundaries:
  - count=0: done pulses at T+1 with no write.
  - Forward base=0x7FFFFF, count=2: addresses 0x7FFFFF then 0x000000.
  - start pulsed while busy has no effect.
- Reset=0 after 2 bytes accepted: no write is issued, the block is in IDLE with all outputs at reset values, and a fresh start then behaves as in the first scenario.

Source files
------------

// File: rtl/flash_word_writer_pkg.sv
// Shared constants, writer state encoding and address-step helper for the
// flash word writer.
package flash_pkg;

    localparam int FLASH_ADDR_W = 23;

    localparam logic [5:0] BURST_SINGLE = 6'd1;
    localparam logic [3:0] BYTE_EN_ALL  = 4'hF;

    localparam logic [FLASH_ADDR_W-1:0] ADDR_ZERO = {FLASH_ADDR_W{1'b0}};
    localparam logic [FLASH_ADDR_W-1:0] ADDR_ONE  = {{(FLASH_ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Next word address; wraps naturally modulo 2^FLASH_ADDR_W in both directions.
    function automatic logic [FLASH_ADDR_W-1:0] next_addr(
        input logic [FLASH_ADDR_W-1:0] addr,
        input logic                    rev
    );
        logic [FLASH_ADDR_W-1:0] res;
        if (rev) begin
            res = addr - ADDR_ONE;
        end else begin
            res = addr + ADDR_ONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/flash_word_writer_if.sv
// Byte-stream, control and Avalon-MM write signals of the flash word writer.
// The master modport is the writer itself; the slave modport is its environment.
interface flash_word_writer_if;
    import flash_pkg::*;

    logic                    start;
    logic                    reverse;
    logic [FLASH_ADDR_W-1:0] base_addr;
    logic [FLASH_ADDR_W-1:0] word_count;
    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    flash_mem_write;
    logic [FLASH_ADDR_W-1:0] flash_mem_address;
    logic [31:0]             flash_mem_writedata;
    logic [3:0]              flash_mem_byteenable;
    logic [5:0]              flash_mem_burstcount;
    logic                    flash_mem_waitrequest;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, reverse, base_addr, word_count, byte_in, byte_valid,
               flash_mem_waitrequest,
        output byte_ready, flash_mem_write, flash_mem_address, flash_mem_writedata,
               flash_mem_byteenable, flash_mem_burstcount, busy, done
    );

    modport slave (
        output start, reverse, base_addr, word_count, byte_in, byte_valid,
               flash_mem_waitrequest,
        input  byte_ready, flash_mem_write, flash_mem_address, flash_mem_writedata,
               flash_mem_byteenable, flash_mem_burstcount, busy, done
    );

endinterface

// File: rtl/flash_word_writer_byte_packer.sv
// Packs accepted bytes into a 32-bit word. Forward order fills lane 0 first,
// reverse order fills lane 3 first. full_o flags the byte that completes a word.
module byte_packer (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic        reverse_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  slot_s;

    // Lane advance and byte insertion into the selected slot.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        slot_s = 2'd0;
        if (clear_i) begin
            lane_d = 2'd0;
        end else if (load_i) begin
            lane_d = lane_q + 2'd1;
            if (reverse_i) begin
                slot_s = 2'd3 - lane_q;
            end else begin
                slot_s = lane_q;
            end
            case (slot_s)
                2'd0:    word_d[7:0]   = byte_i;
                2'd1:    word_d[15:8]  = byte_i;
                2'd2:    word_d[23:16] = byte_i;
                2'd3:    word_d[31:24] = byte_i;
                default: word_d        = word_q;
            endcase
        end else begin
            lane_d = lane_q;
        end
    end

    // Lane counter and word register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            lane_q <= 2'd0;
            word_q <= 32'h0000_0000;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign full_o = load_i && (lane_q == 2'd3);

endmodule

// File: rtl/flash_word_writer.sv
// Flash word writer: collects four stream bytes per word and issues each word
// as a single-beat Avalon-MM write, stepping the address up or down.
module flash_word_writer
    import flash_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_ni,
    flash_word_writer_if.master  bus
);

    wr_state_e               state_q, state_d;
    logic                    rev_q, rev_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [FLASH_ADDR_W-1:0] rem_q, rem_d;
    logic                    byte_ready_q;
    logic                    write_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    clear_s;
    logic                    load_s;
    logic                    full_s;
    logic [31:0]             word_s;

    byte_packer u_packer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .clear_i   (clear_s),
        .load_i    (load_s),
        .reverse_i (rev_q),
        .byte_i    (bus.byte_in),
        .word_o    (word_s),
        .full_o    (full_s)
    );

    // Next-state, transfer bookkeeping and packer control.
    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        clear_s = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rev_d   = bus.reverse;
                    addr_d  = bus.base_addr;
                    rem_d   = bus.word_count;
                    clear_s = 1'b1;
                    if (bus.word_count == ADDR_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                load_s = bus.byte_valid;
                if (full_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (!bus.flash_mem_waitrequest) begin
                    rem_d  = rem_q - ADDR_ONE;
                    addr_d = next_addr(addr_q, rev_q);
                    if (rem_q == ADDR_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                        clear_s = 1'b1;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, transfer registers and state-decoded outputs registered together.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            rev_q        <= 1'b0;
            addr_q       <= ADDR_ZERO;
            rem_q        <= ADDR_ZERO;
            byte_ready_q <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rev_q        <= rev_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            byte_ready_q <= (state_d == ST_FILL);
            write_q      <= (state_d == ST_WRITE);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign bus.byte_ready           = byte_ready_q;
    assign bus.flash_mem_write      = write_q;
    assign bus.flash_mem_address    = addr_q;
    assign bus.flash_mem_writedata  = word_s;
    assign bus.flash_mem_byteenable = BYTE_EN_ALL;
    assign bus.flash_mem_burstcount = BURST_SINGLE;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;

endmodule

// File: tb/tb_flash_word_writer.sv
// Self-checking bench for flash_word_writer: behavioural transfer model checked
// every cycle, per-run word scoreboard, and literal expectations for fixed cases.
module tb_flash_word_writer;
    import flash_pkg::*;

    localparam int AW      = FLASH_ADDR_W;
    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_WRITE = 2;
    localparam int P_DONE  = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    flash_word_writer_if bus_if();

    flash_word_writer dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int              m_phase = P_IDLE;
    bit              m_rev   = 1'b0;
    logic [AW-1:0]   m_base  = '0;
    logic [AW-1:0]   m_left  = '0;
    int              m_widx  = 0;
    int              m_k     = 0;
    logic [31:0]     m_word  = 32'h0;
    bit              m_clean = 1'b1;

    // observation
    int cyc = 0, bytes_acc = 0, stall_cyc = 0, acc_cyc = 0, done_cyc = 0, start_cyc = 0, done_cnt = 0;
    bit acc_byte = 1'b0, acc_wr = 1'b0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];

    // stimulus
    logic [7:0] src_q[$];
    int gmode = 0, wmode = 0, gap_ph = 0, stall_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int idx, input bit rev);
        logic [AW-1:0] off;
        off = idx[AW-1:0];
        return rev ? (base - off) : (base + off);
    endfunction

    // Compare process: check outputs against the model, then advance the model
    // to what the coming rising edge must do.
    always @(negedge clk) begin
        cyc++;
        chk("byteenable", 32'(bus_if.flash_mem_byteenable), 32'h0000_000F);
        chk("burstcount", 32'(bus_if.flash_mem_burstcount), 32'd1);
        chk("busy",       32'(bus_if.busy),            32'(m_phase != P_IDLE));
        chk("byte_ready", 32'(bus_if.byte_ready),      32'(m_phase == P_FILL));
        chk("write",      32'(bus_if.flash_mem_write), 32'(m_phase == P_WRITE));
        chk("done",       32'(bus_if.done),            32'(m_phase == P_DONE));
        if (m_phase == P_WRITE) begin
            chk("wr_addr", 32'(bus_if.flash_mem_address), 32'(exp_addr(m_base, m_widx, m_rev)));
            chk("wr_data", bus_if.flash_mem_writedata, m_word);
        end
        if (m_clean) begin
            chk("rst_addr", 32'(bus_if.flash_mem_address), 32'h0);
            chk("rst_data", bus_if.flash_mem_writedata, 32'h0);
        end
        if (bus_if.flash_mem_write && bus_if.flash_mem_waitrequest) stall_cyc++;
        if (bus_if.done) begin done_cyc = cyc; done_cnt++; end
        acc_byte = bus_if.byte_valid && bus_if.byte_ready && reset_n;
        acc_wr   = bus_if.flash_mem_write && !bus_if.flash_mem_waitrequest && reset_n;
        if (acc_wr) begin
            log_addr.push_back(bus_if.flash_mem_address);
            log_data.push_back(bus_if.flash_mem_writedata);
            acc_cyc = cyc;
        end
        if (!reset_n) begin
            m_phase = P_IDLE;
            m_clean = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: if (bus_if.start) begin
                    m_rev = bus_if.reverse; m_base = bus_if.base_addr; m_left = bus_if.word_count;
                    m_widx = 0; m_k = 0; m_word = 32'h0; m_clean = 1'b0; start_cyc = cyc;
                    m_phase = (bus_if.word_count == '0) ? P_DONE : P_FILL;
                end
                P_FILL: if (bus_if.byte_valid) begin
                    m_word = m_word | (32'(bus_if.byte_in) << (m_rev ? (24 - 8 * m_k) : (8 * m_k)));
                    m_k++;
                    bytes_acc++;
                    if (m_k == 4) m_phase = P_WRITE;
                end
                P_WRITE: if (!bus_if.flash_mem_waitrequest) begin
                    m_left = m_left - 1'b1;
                    m_widx++;
                    m_k = 0;
                    m_word = 32'h0;
                    m_phase = (m_left == '0) ? P_DONE : P_FILL;
                end
                P_DONE: m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Advance one cycle and drive the source and slave stall for the next edge.
    task automatic step();
        bit go;
        logic [31:0] r;
        @(posedge clk);
        #1;
        if (acc_byte && src_q.size() > 0) void'(src_q.pop_front());
        if (!(bus_if.byte_valid && !acc_byte)) begin
            r = $urandom;
            case (gmode)
                0:       go = 1'b1;
                1:       go = (r[1:0] != 2'b00);
                default: go = (gap_ph == 0);
            endcase
            bus_if.byte_valid = go && (src_q.size() > 0);
            bus_if.byte_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
        gap_ph = (gap_ph == 2) ? 0 : gap_ph + 1;
        r = $urandom;
        case (wmode)
            0: bus_if.flash_mem_waitrequest = 1'b0;
            1: bus_if.flash_mem_waitrequest = r[0];
            default: begin
                if (bus_if.flash_mem_write && stall_cnt < 3) begin
                    bus_if.flash_mem_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    bus_if.flash_mem_waitrequest = 1'b0;
                    if (!bus_if.flash_mem_write) stall_cnt = 0;
                end
            end
        endcase
    endtask

    // One transfer: bytes must already be in src_q. glitch_at>=0 pulses a
    // bogus start that many cycles in.
    task automatic run(input bit rev, input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input int gm, input int wm, input int glitch_at);
        logic [7:0]  b[$];
        logic [31:0] w;
        int n;
        b = src_q;
        gmode = gm; wmode = wm; stall_cnt = 0;
        log_addr.delete(); log_data.delete();
        bus_if.start = 1'b1; bus_if.reverse = rev; bus_if.base_addr = base; bus_if.word_count = cnt;
        step();
        bus_if.start = 1'b0;
        n = 0;
        while (m_phase != P_IDLE && n < 3000) begin
            if (n == glitch_at) begin
                bus_if.start = 1'b1; bus_if.reverse = ~rev;
                bus_if.base_addr = 23'h000555; bus_if.word_count = 23'd7;
            end else begin
                bus_if.start = 1'b0;
            end
            step();
            n++;
        end
        bus_if.start = 1'b0;
        chk("run_finished", 32'(m_phase == P_IDLE), 32'd1);
        chk("word_total", 32'(log_data.size()), 32'(cnt));
        for (int i = 0; i < int'(cnt) && i < log_data.size() && 4 * i + 3 < b.size(); i++) begin
            if (rev) w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            else     w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            chk("sb_data", log_data[i], w);
            chk("sb_addr", 32'(log_addr[i]), 32'(exp_addr(base, i, rev)));
        end
        step();
    endtask

    task automatic load_bytes(input logic [31:0] v0, input logic [31:0] v1, input int nwords);
        logic [31:0] v;
        for (int i = 0; i < nwords; i++) begin
            v = (i == 0) ? v0 : v1;
            for (int j = 0; j < 4; j++) src_q.push_back(v[31-8*j -: 8]);
        end
    endtask

    initial begin
        logic [31:0] r;
        int bstart, n, rcnt;
        bus_if.start = 1'b0; bus_if.reverse = 1'b0; bus_if.base_addr = '0; bus_if.word_count = '0;
        bus_if.byte_in = 8'h00; bus_if.byte_valid = 1'b0; bus_if.flash_mem_waitrequest = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("reset_ready", 32'(bus_if.byte_ready), 32'd0);
        chk("reset_busy",  32'(bus_if.busy), 32'd0);

        // forward single word
        load_bytes(32'h11223344, 32'h0, 1);
        run(1'b0, 23'h000010, 23'd1, 0, 0, -1);
        chk("s1_data", log_data.size() > 0 ? log_data[0] : 32'hDEAD_BEEF, 32'h44332211);
        chk("s1_addr", log_addr.size() > 0 ? 32'(log_addr[0]) : 32'hDEAD_BEEF, 32'h00000010);
        chk("s1_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // reverse two words
        load_bytes(32'hAABBCCDD, 32'h01020304, 2);
        run(1'b1, 23'h000020, 23'd2, 0, 0, -1);
        chk("s2_data0", log_data.size() > 1 ? log_data[0] : 32'hDEAD_BEEF, 32'hAABBCCDD);
        chk("s2_addr1", log_addr.size() > 1 ? 32'(log_addr[1]) : 32'hDEAD_BEEF, 32'h0000001F);
        chk("s2_data1", log_data.size() > 1 ? log_data[1] : 32'hDEAD_BEEF, 32'h01020304);

        // three-cycle stall
        stall_cyc = 0;
        load_bytes(32'h55667788, 32'h0, 1);
        run(1'b0, 23'h000100, 23'd1, 0, 2, -1);
        chk("s3_stalls", 32'(stall_cyc), 32'd3);
        chk("s3_data", log_data.size() > 0 ? log_data[0] : 32'hDEAD_BEEF, 32'h88776655);

        // source gaps 1,0,0,1,...
        gap_ph = 0;
        load_bytes(32'h01020304, 32'h05060708, 2);
        run(1'b0, 23'h000200, 23'd2, 2, 0, -1);
        chk("s4_data1", log_data.size() > 1 ? log_data[1] : 32'hDEAD_BEEF, 32'h08070605);

        // zero count
        n = done_cnt;
        run(1'b0, 23'h000300, 23'd0, 0, 0, -1);
        chk("s5_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        chk("s5_done_cnt", 32'(done_cnt - n), 32'd1);

        // forward wrap
        load_bytes(32'hC0FFEE00, 32'h12345678, 2);
        run(1'b0, 23'h7FFFFF, 23'd2, 0, 1, -1);
        chk("s6_addr0", log_addr.size() > 1 ? 32'(log_addr[0]) : 32'hDEAD_BEEF, 32'h007FFFFF);
        chk("s6_addr1", log_addr.size() > 1 ? 32'(log_addr[1]) : 32'hDEAD_BEEF, 32'h00000000);

        // start while busy is ignored
        load_bytes(32'hA1A2A3A4, 32'h0, 1);
        run(1'b0, 23'h000040, 23'd1, 0, 0, 1);
        chk("s7_addr", log_addr.size() > 0 ? 32'(log_addr[0]) : 32'hDEAD_BEEF, 32'h00000040);

        // reset after two bytes
        log_addr.delete(); log_data.delete();
        gmode = 0; wmode = 0;
        load_bytes(32'h11223344, 32'h0, 1);
        bus_if.start = 1'b1; bus_if.reverse = 1'b0; bus_if.base_addr = 23'h000010; bus_if.word_count = 23'd1;
        bstart = bytes_acc;
        step();
        bus_if.start = 1'b0;
        n = 0;
        while (bytes_acc - bstart < 2 && n < 50) begin step(); n++; end
        chk("s8_two_bytes", 32'(bytes_acc - bstart), 32'd2);
        reset_n = 1'b0;
        src_q.delete();
        bus_if.byte_valid = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) step();
        chk("s8_no_write", 32'(log_data.size()), 32'd0);
        chk("s8_busy", 32'(bus_if.busy), 32'd0);
        chk("s8_data", bus_if.flash_mem_writedata, 32'h0);
        load_bytes(32'h11223344, 32'h0, 1);
        run(1'b0, 23'h000010, 23'd1, 0, 0, -1);
        chk("s8_redo_data", log_data.size() > 0 ? log_data[0] : 32'hDEAD_BEEF, 32'h44332211);

        // randomized transfers
        for (int t = 0; t < 24; t++) begin
            r = $urandom;
            rcnt = 1 + int'(r[1:0]);
            for (int i = 0; i < 4 * rcnt; i++) begin
                r = $urandom;
                src_q.push_back(r[7:0]);
            end
            r = $urandom;
            if (t % 6 == 0) r[22:0] = r[0] ? 23'h7FFFFE : 23'h000001;
            run(r[23], r[22:0], 23'(rcnt), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                (t % 4 == 0) ? 2 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
